// File: rtl/game_round_controller.sv
// Match-level sequencer above the game master FSM: end-of-game timer, score,
// lives, level and target speed, with a game-over hold released by a fresh key press.
module game_round_controller #(
   parameter int SCORE_W        = 8,
   parameter int LIVES_W        = 2,
   parameter int LIVES_INIT     = 3,
   parameter int SPEED_W        = 3,
   parameter int SPEED_INIT     = 1,
   parameter int SPEED_MAX      = 7,
   parameter int WINS_PER_LEVEL = 4,
   parameter int TIMER_W        = 8,
   parameter int ROUND_FRAMES   = 60,
   parameter int OVER_FRAMES    = 180
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               key,
   input  logic               end_of_game_timer_start,
   input  logic               game_won,
   output logic               end_of_game_timer_running,
   output logic [SCORE_W-1:0] score,
   output logic [LIVES_W-1:0] lives,
   output logic [SPEED_W-1:0] target_speed,
   output logic               level_up,
   output logic               match_over
);

   // state     | meaning
   // PLAY      | round in progress, waiting for timer_start from the master
   // ROUND_END | counting ROUND_FRAMES ticks after a won/lost round
   // OVER_WAIT | counting OVER_FRAMES ticks after the final loss
   // OVER_HOLD | game over, waiting for a fresh key press to restart
   typedef enum logic [1:0] {S_PLAY, S_ROUND_END, S_OVER_WAIT, S_OVER_HOLD} state_t;

   localparam int WIN_W = $clog2(WINS_PER_LEVEL + 1);

   localparam logic [SCORE_W-1:0] SCORE_TOP  = '1;
   localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
   localparam logic [LIVES_W-1:0] LIVES_RST  = LIVES_W'(LIVES_INIT);
   localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
   localparam logic [SPEED_W-1:0] SPEED_RST  = SPEED_W'(SPEED_INIT);
   localparam logic [SPEED_W-1:0] SPEED_TOP  = SPEED_W'(SPEED_MAX);
   localparam logic [SPEED_W-1:0] SPEED_ONE  = SPEED_W'(1);
   localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINS_PER_LEVEL - 1);
   localparam logic [WIN_W-1:0]   WIN_ONE    = WIN_W'(1);
   localparam logic [TIMER_W-1:0] T_ROUND    = TIMER_W'(ROUND_FRAMES);
   localparam logic [TIMER_W-1:0] T_OVER     = TIMER_W'(OVER_FRAMES);
   localparam logic [TIMER_W-1:0] T_ONE      = TIMER_W'(1);

   state_t             state_q, state_d;
   logic               running_q, running_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic               level_up_q, level_up_d;
   logic               match_over_q, match_over_d;
   logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               key_q, key_d;

   always_comb begin
      state_d      = state_q;
      running_d    = running_q;
      score_d      = score_q;
      lives_d      = lives_q;
      speed_d      = speed_q;
      level_up_d   = 1'b0;
      match_over_d = match_over_q;
      win_cnt_d    = win_cnt_q;
      timer_d      = timer_q;
      key_d        = key;

      unique case (state_q)
         S_PLAY: begin
            if (end_of_game_timer_start) begin
               running_d = 1'b1;
               timer_d   = T_ROUND;
               state_d   = S_ROUND_END;
               if (game_won) begin
                  if (score_q != SCORE_TOP) score_d = score_q + SCORE_ONE;
                  if (win_cnt_q == WIN_LAST) begin
                     win_cnt_d = '0;
                     if (speed_q < SPEED_TOP) begin
                        speed_d    = speed_q + SPEED_ONE;
                        level_up_d = 1'b1;
                     end
                  end else begin
                     win_cnt_d = win_cnt_q + WIN_ONE;
                  end
               end else begin
                  win_cnt_d = '0;
                  lives_d   = lives_q - LIVES_ONE;
                  if (lives_q == LIVES_ONE) begin
                     match_over_d = 1'b1;
                     timer_d      = T_OVER;
                     state_d      = S_OVER_WAIT;
                  end
               end
            end
         end
         S_ROUND_END, S_OVER_WAIT: begin
            if (frame_tick) begin
               if (timer_q == T_ONE) begin
                  timer_d = '0;
                  if (state_q == S_ROUND_END) begin
                     running_d = 1'b0;
                     state_d   = S_PLAY;
                  end else begin
                     state_d   = S_OVER_HOLD;
                  end
               end else begin
                  timer_d = timer_q - T_ONE;
               end
            end
         end
         S_OVER_HOLD: begin
            // key_q tracks the key in every state, so a press held across entry is not an edge
            if (key && !key_q) begin
               score_d      = '0;
               lives_d      = LIVES_RST;
               speed_d      = SPEED_RST;
               win_cnt_d    = '0;
               match_over_d = 1'b0;
               running_d    = 1'b0;
               state_d      = S_PLAY;
            end
         end
         default: state_d = S_PLAY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_PLAY;
         running_q    <= 1'b0;
         score_q      <= '0;
         lives_q      <= LIVES_RST;
         speed_q      <= SPEED_RST;
         level_up_q   <= 1'b0;
         match_over_q <= 1'b0;
         win_cnt_q    <= '0;
         timer_q      <= '0;
         key_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         running_q    <= running_d;
         score_q      <= score_d;
         lives_q      <= lives_d;
         speed_q      <= speed_d;
         level_up_q   <= level_up_d;
         match_over_q <= match_over_d;
         win_cnt_q    <= win_cnt_d;
         timer_q      <= timer_d;
         key_q        <= key_d;
      end
   end

   assign end_of_game_timer_running = running_q;
   assign score                     = score_q;
   assign lives                     = lives_q;
   assign target_speed              = speed_q;
   assign level_up                  = level_up_q;
   assign match_over                = match_over_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Self-checking bench for game_round_controller: randomized tick spacing and round
// outcomes against a match-level model of score, lives, speed and level progress.
module tb_game_round_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_tick = 1'b0;
   logic        key = 1'b0;
   logic        end_of_game_timer_start = 1'b0;
   logic        game_won = 1'b0;
   logic        running;
   logic [7:0]  score;
   logic [1:0]  lives;
   logic [2:0]  target_speed;
   logic        level_up;
   logic        match_over;
   logic [15:0] dut_vec;

   int total = 0;
   int bad   = 0;
   int max_gap = 2;

   // match-level model
   int exp_score, exp_lives, exp_speed, exp_wins;

   game_round_controller dut (
      .clk                       (clk),
      .reset                     (reset),
      .frame_tick                (frame_tick),
      .key                       (key),
      .end_of_game_timer_start   (end_of_game_timer_start),
      .game_won                  (game_won),
      .end_of_game_timer_running (running),
      .score                     (score),
      .lives                     (lives),
      .target_speed              (target_speed),
      .level_up                  (level_up),
      .match_over                (match_over)
   );

   always #5 clk = ~clk;

   assign dut_vec = {running, match_over, level_up, score, lives, target_speed};

   function automatic logic [15:0] exp_vec(input bit run, input bit mo, input bit lu);
      logic [7:0] s;
      logic [1:0] l;
      logic [2:0] v;
      s = exp_score[7:0];
      l = exp_lives[1:0];
      v = exp_speed[2:0];
      return {run, mo, lu, s, l, v};
   endfunction

   function automatic void model_reset();
      exp_score = 0;
      exp_lives = 3;
      exp_speed = 1;
      exp_wins  = 0;
   endfunction

   function automatic void model_round(input bit won, output bit lu, output bit over);
      lu   = 1'b0;
      over = 1'b0;
      if (won) begin
         exp_score = (exp_score >= 255) ? 255 : exp_score + 1;
         exp_wins  = exp_wins + 1;
         if (exp_wins == 4) begin
            exp_wins = 0;
            if (exp_speed < 7) begin
               exp_speed = exp_speed + 1;
               lu = 1'b1;
            end
         end
      end else begin
         exp_wins  = 0;
         exp_lives = exp_lives - 1;
         over      = (exp_lives == 0);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic start_round(input bit won, input bit with_tick);
      end_of_game_timer_start = 1'b1;
      game_won   = won;
      frame_tick = with_tick;
      step();
      end_of_game_timer_start = 1'b0;
      game_won   = 1'($urandom);
      frame_tick = 1'b0;
   endtask

   // issues up to limit ticks with random spacing; stops early once running drops
   task automatic count_ticks(input int limit, output int n);
      n = 0;
      while (n < limit) begin
         repeat ($urandom_range(0, max_gap)) step();
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         n++;
         if (!running) break;
      end
   endtask

   task automatic test_round(input bit won, input bit with_tick, output bit over);
      bit lu;
      int n;
      start_round(won, with_tick);
      model_round(won, lu, over);
      total++;
      if (dut_vec !== exp_vec(1'b1, over, lu)) begin
         bad++;
         $display("FAIL round_start won=%0b got=%h want=%h", won, dut_vec, exp_vec(1'b1, over, lu));
      end
      step();
      total++;
      if (level_up !== 1'b0) begin
         bad++;
         $display("FAIL level_up_width got=%b want=0", level_up);
      end
      if (!over) begin
         count_ticks(1000, n);
         total++;
         if (n != 60) begin
            bad++;
            $display("FAIL round_ticks got=%0d want=60", n);
         end
         total++;
         if (dut_vec !== exp_vec(1'b0, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL round_end got=%h want=%h", dut_vec, exp_vec(1'b0, 1'b0, 1'b0));
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (dut_vec !== exp_vec(1'b0, 1'b0, 1'b0)) begin
         bad++;
         $display("FAIL reset_values got=%h want=%h", dut_vec, exp_vec(1'b0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_single_win();
      bit over;
      do_reset();
      test_round(1'b1, 1'b0, over);
   endtask

   task automatic test_level_up();
      bit over;
      do_reset();
      for (int i = 0; i < 4; i++) test_round(1'b1, 1'b0, over);
      do_reset();
      for (int i = 0; i < 3; i++) test_round(1'b1, 1'b0, over);
      test_round(1'b0, 1'b0, over);
      for (int i = 0; i < 4; i++) test_round(1'b1, 1'b0, over);
   endtask

   task automatic test_saturate();
      bit over;
      do_reset();
      max_gap = 1;
      for (int i = 0; i < 28; i++) test_round(1'b1, 1'b0, over);
      total++;
      if (target_speed !== 3'd7) begin
         bad++;
         $display("FAIL speed_saturated got=%0d want=7", target_speed);
      end
      max_gap = 0;
      while (exp_score < 255) test_round(1'b1, 1'b0, over);
      test_round(1'b1, 1'b0, over);
      total++;
      if (score !== 8'd255) begin
         bad++;
         $display("FAIL score_saturated got=%0d want=255", score);
      end
      max_gap = 2;
   endtask

   task automatic test_game_over();
      bit over;
      int n;
      do_reset();
      for (int i = 0; i < 3; i++) test_round(1'b0, 1'b0, over);
      total++;
      if (over !== 1'b1 || lives !== 2'd0) begin
         bad++;
         $display("FAIL over_entry lives got=%0d want=0", lives);
      end
      count_ticks(179, n);
      total++;
      if (n != 179 || dut_vec !== exp_vec(1'b1, 1'b1, 1'b0)) begin
         bad++;
         $display("FAIL over_wait n=%0d got=%h want=%h", n, dut_vec, exp_vec(1'b1, 1'b1, 1'b0));
      end
      key = 1'b1;
      repeat (3) step();
      count_ticks(1, n);
      repeat (5) step();
      total++;
      if (dut_vec !== exp_vec(1'b1, 1'b1, 1'b0)) begin
         bad++;
         $display("FAIL held_key_no_restart got=%h want=%h", dut_vec, exp_vec(1'b1, 1'b1, 1'b0));
      end
      key = 1'b0;
      repeat (2) step();
      total++;
      if (match_over !== 1'b1) begin
         bad++;
         $display("FAIL release_no_restart got=%b want=1", match_over);
      end
      key = 1'b1;
      step();
      key = 1'b0;
      model_reset();
      total++;
      if (dut_vec !== exp_vec(1'b0, 1'b0, 1'b0)) begin
         bad++;
         $display("FAIL restart got=%h want=%h", dut_vec, exp_vec(1'b0, 1'b0, 1'b0));
      end
      test_round(1'b1, 1'b0, over);
   endtask

   task automatic test_coincident();
      bit over;
      int n1, n2;
      do_reset();
      test_round(1'b1, 1'b1, over);
      start_round(1'b1, 1'b0);
      model_round(1'b1, over, over);
      count_ticks(20, n1);
      start_round(1'b1, 1'b0);
      total++;
      if (score !== 8'd2 || running !== 1'b1) begin
         bad++;
         $display("FAIL start_ignored score got=%0d want=2 running=%b", score, running);
      end
      count_ticks(1000, n2);
      total++;
      if (n1 + n2 != 60) begin
         bad++;
         $display("FAIL ignored_start_ticks got=%0d want=60", n1 + n2);
      end
   endtask

   task automatic test_reset_mid();
      bit over;
      int n;
      do_reset();
      start_round(1'b1, 1'b0);
      count_ticks(10, n);
      do_reset();
      total++;
      if (dut_vec !== exp_vec(1'b0, 1'b0, 1'b0)) begin
         bad++;
         $display("FAIL reset_mid_round got=%h want=%h", dut_vec, exp_vec(1'b0, 1'b0, 1'b0));
      end
      for (int i = 0; i < 3; i++) test_round(1'b0, 1'b0, over);
      count_ticks(180, n);
      repeat (4) step();
      do_reset();
      total++;
      if (dut_vec !== exp_vec(1'b0, 1'b0, 1'b0)) begin
         bad++;
         $display("FAIL reset_mid_hold got=%h want=%h", dut_vec, exp_vec(1'b0, 1'b0, 1'b0));
      end
      test_round(1'b1, 1'b0, over);
   endtask

   task automatic test_random();
      bit over;
      bit won;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         max_gap = $urandom_range(0, 3);
         won = 1'($urandom);
         if (exp_lives == 1) won = 1'b1;
         test_round(won, 1'($urandom_range(0, 1)), over);
      end
      max_gap = 2;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_single_win();
      test_level_up();
      test_saturate();
      test_game_over();
      test_coincident();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
